// File: rtl/div_clk_bridge.sv
// div_clk_bridge: single-clock rate bridge from fast-side producer logic to a
// consumer clocked by clk_divided. Words are buffered in a small FIFO and
// presented on out_data/out_valid, which update only after a slow falling
// edge, so they are stable across every slow rising edge.
// Optional build macro: DIV_CLK_BRIDGE_STATS_EN adds the xfer_cnt port, which
// counts completed slow-side transfers.

`ifndef DIV_RATIO_HALF
`define DIV_RATIO_HALF 4
`endif
`ifndef BITS_DIV_RATIO_HALF
`define BITS_DIV_RATIO_HALF 2
`endif

module div_clk_bridge #(
  parameter int DATA_WIDTH          = 32,
  parameter int FIFO_DEPTH          = 4,
  parameter int DIV_RATIO_HALF      = `DIV_RATIO_HALF,
  parameter int BITS_DIV_RATIO_HALF = `BITS_DIV_RATIO_HALF
) (
  input  logic                           clk,
  input  logic                           rst_b,
  input  logic [BITS_DIV_RATIO_HALF-1:0] clk_div_ctr,
  input  logic                           clk_divided,
  input  logic                           in_valid,
  input  logic [DATA_WIDTH-1:0]          in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  input  logic                           out_ready
`ifdef DIV_CLK_BRIDGE_STATS_EN
  ,
  output logic [31:0]                    xfer_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [BITS_DIV_RATIO_HALF-1:0] TERM_VAL =
    BITS_DIV_RATIO_HALF'(DIV_RATIO_HALF - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    EMPTY,
    PRESENT,
    ACCEPTED
  } slot_state_t;

  logic                  term;
  logic                  launch;
  logic                  capture;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  slot_state_t           state;

  // Strobes fire in the fast cycle just before the clk_divided edge.
  assign term    = (clk_div_ctr == TERM_VAL);
  assign launch  = term & clk_divided;
  assign capture = term & ~clk_divided;

  // Ready depends on the registered count only; a same-cycle pop does not
  // open a slot for a push.
  assign in_ready   = (count != FULL_CNT);
  assign push       = in_valid & in_ready;
  assign fifo_empty = (count == '0);

  // A new word may enter the slot at a slow falling edge unless the current
  // word is still waiting to be accepted.
  assign pop = launch & ~fifo_empty & (state != PRESENT);

  // Storage write port.
  // NOTE: the storage array has no reset; words are only observable through
  // the pointers and count, which are reset, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Pointer and occupancy bookkeeping; push and pop together leave count as is.
  // NOTE: all state is updated with non-blocking assignments so every register
  // sees pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Output slot FSM with registered out_valid/out_data.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (pop) begin
            out_data  <= mem[rd_ptr];
            out_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (capture && out_ready) state <= ACCEPTED;
        end
        ACCEPTED: begin
          if (launch) begin
            if (pop) begin
              out_data <= mem[rd_ptr];
              state    <= PRESENT;
            end else begin
              out_valid <= 1'b0;
              state     <= EMPTY;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= EMPTY;
        end
      endcase
    end
  end

`ifdef DIV_CLK_BRIDGE_STATS_EN
  // Count completed slow-side handshakes; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      xfer_cnt <= '0;
    end else if (state == PRESENT && capture && out_ready) begin
      xfer_cnt <= xfer_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_div_clk_bridge.sv
// tb_div_clk_bridge: scoreboard bench for div_clk_bridge. Two instances are
// built, one with DIV_RATIO_HALF=4 and one with DIV_RATIO_HALF=1; a select
// signal routes the shared stimulus and the monitor to one of them.

module tb_div_clk_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b;
  logic        div_rst_b;
  logic        sel;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  // Bench-side clock dividers
  logic [1:0]  ctr4;
  logic        div4;
  logic [0:0]  ctr1;
  logic        div1;

  logic        in_valid4, in_valid1;
  logic        in_ready4, in_ready1;
  logic        out_valid4, out_valid1;
  logic [31:0] out_data4, out_data1;
`ifdef DIV_CLK_BRIDGE_STATS_EN
  logic [31:0] xfer_cnt4, xfer_cnt1;
`endif

  logic        in_ready, out_valid, launch_m, capture_m;
  logic [31:0] out_data;

  assign ctr1      = 1'b0;
  assign in_valid4 = in_valid & ~sel;
  assign in_valid1 = in_valid & sel;
  assign in_ready  = sel ? in_ready1  : in_ready4;
  assign out_valid = sel ? out_valid1 : out_valid4;
  assign out_data  = sel ? out_data1  : out_data4;
  assign launch_m  = sel ? div1  : ((ctr4 == 2'd3) &  div4);
  assign capture_m = sel ? ~div1 : ((ctr4 == 2'd3) & ~div4);

  div_clk_bridge #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .DIV_RATIO_HALF(4), .BITS_DIV_RATIO_HALF(2)) u_dut4 (
    .clk(clk), .rst_b(rst_b), .clk_div_ctr(ctr4), .clk_divided(div4),
    .in_valid(in_valid4), .in_data(in_data), .in_ready(in_ready4),
    .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready)
`ifdef DIV_CLK_BRIDGE_STATS_EN
    , .xfer_cnt(xfer_cnt4)
`endif
  );

  div_clk_bridge #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .DIV_RATIO_HALF(1), .BITS_DIV_RATIO_HALF(1)) u_dut1 (
    .clk(clk), .rst_b(rst_b), .clk_div_ctr(ctr1), .clk_divided(div1),
    .in_valid(in_valid1), .in_data(in_data), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready & sel)
`ifdef DIV_CLK_BRIDGE_STATS_EN
    , .xfer_cnt(xfer_cnt1)
`endif
  );

  // Free-running dividers: half period of 4 and of 1 fast cycles
  always @(posedge clk) begin
    if (!div_rst_b) begin
      ctr4 <= 2'd0;
      div4 <= 1'b0;
      div1 <= 1'b0;
    end else begin
      div1 <= ~div1;
      if (ctr4 == 2'd3) begin
        ctr4 <= 2'd0;
        div4 <= ~div4;
      end else begin
        ctr4 <= ctr4 + 2'd1;
      end
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int xfers = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Cycle counter and reset-at-edge marker for the monitor
  logic rst_edge = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= !rst_b;
  end

  // Monitor: slow-side transfers against the scoreboard, output change phase,
  // and transfer spacing.
  bit          mon_en = 1'b0;
  bit          started = 1'b0;
  bit          prev_launch;
  logic        prev_v;
  logic [31:0] prev_d;
  bit          gap_en = 1'b0;
  bit          have_last = 1'b0;
  int          gap_exp = 0;
  int          last_xfer = 0;

  always @(negedge clk) begin
    if (!mon_en) begin
      started = 1'b0;
    end else begin
      if (started && !rst_edge && (out_valid !== prev_v || out_data !== prev_d))
        check("change_after_launch", {31'd0, prev_launch}, 32'd1);
      if (capture_m && out_ready && out_valid && rst_b) begin
        if (exp_q.size() == 0) check("extra_word", exp_q.size(), 32'd1);
        else check("word_order", out_data, exp_q.pop_front());
        xfers++;
        if (gap_en && have_last) check("xfer_gap", cyc - last_xfer, gap_exp);
        last_xfer = cyc;
        have_last = 1'b1;
      end
      started     = 1'b1;
      prev_v      = out_valid;
      prev_d      = out_data;
      prev_launch = launch_m;
    end
  end

  task automatic push_word(input logic [31:0] d);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("push_timeout", waited, 32'd0);
    else exp_q.push_back(d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_b    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, hold, base, n;
    bit saw;
    rst_b = 1'b0; div_rst_b = 1'b0; sel = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    div_rst_b = 1'b1;
    rst_b     = 1'b1;

    // Reset values on both instances
    check("rst_out_valid4", out_valid4, 32'd0);
    check("rst_in_ready4",  in_ready4,  32'd1);
    check("rst_out_data4",  out_data4,  32'd0);
    check("rst_out_valid1", out_valid1, 32'd0);
    check("rst_in_ready1",  in_ready1,  32'd1);
`ifdef DIV_CLK_BRIDGE_STATS_EN
    check("rst_xfer_cnt4", xfer_cnt4, 32'd0);
`endif
    mon_en = 1'b1;

    // Reset mid-operation: three words buffered, then a one-cycle reset
    out_ready = 1'b0;
    push_word(32'h11);
    push_word(32'h22);
    push_word(32'h33);
    repeat (6) @(negedge clk);
    pulse_reset();
    check("midrst_out_valid", out_valid, 32'd0);
    check("midrst_in_ready",  in_ready,  32'd1);
    check("midrst_out_data",  out_data,  32'd0);
    exp_q.delete();
    out_ready = 1'b1;
    saw = 1'b0;
    repeat (24) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check("no_stale_word", {31'd0, saw}, 32'd0);

    // Single word at an arbitrary divider phase
    repeat ($urandom_range(0, 7)) @(negedge clk);
    push_word(32'hA5);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    check("a5_lat_max", {31'd0, lat <= 9}, 32'd1);
    check("a5_lat_min", {31'd0, lat >= 2}, 32'd1);
    check("a5_data", out_data, 32'hA5);
    hold = 0;
    while (out_valid && hold < 40) begin
      hold++;
      @(negedge clk);
    end
    check("a5_hold", hold, 32'd8);
    check("a5_gone", out_valid, 32'd0);
    drain(50);

    // Back-pressure: slot plus four FIFO words, sixth word waits
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push_word(32'(i));
    in_valid = 1'b1;
    in_data  = 32'h6;
    repeat (24) @(negedge clk);
    check("bp_in_ready",  in_ready,  32'd0);
    check("bp_out_valid", out_valid, 32'd1);
    check("bp_out_data",  out_data,  32'h1);
    gap_en = 1'b1; gap_exp = 8; have_last = 1'b0;
    out_ready = 1'b1;
    push_word(32'h6);
    drain(200);
    gap_en = 1'b0;

    // Push aligned with a launch while the FIFO is full
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(32'h41 + 32'(i));
    repeat (4) @(negedge clk);
    check("full_in_ready", in_ready, 32'd0);
    out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!capture_m && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    while (!launch_m && n < 80) begin @(negedge clk); n++; end
    check("align_found", {31'd0, launch_m}, 32'd1);
    in_valid = 1'b1;
    in_data  = 32'h46;
    check("full_at_launch", in_ready, 32'd0);
    @(negedge clk);
    check("ready_after_pop", in_ready, 32'd1);
    exp_q.push_back(32'h46);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain(200);

    // Half ratio of one: streaming 0x10..0x1F
    @(negedge clk);
    mon_en = 1'b0;
    sel    = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    gap_en = 1'b1; gap_exp = 2; have_last = 1'b0;
    out_ready = 1'b1;
    base = xfers;
    for (int i = 16; i < 32; i++) push_word(32'(i));
    drain(200);
    check("r1_xfers", xfers - base, 32'd16);
`ifdef DIV_CLK_BRIDGE_STATS_EN
    check("r1_xfer_cnt", xfer_cnt1, 32'd16);
`endif
    gap_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
